// File: rtl/terrain_pkg.sv
// Shared constants, FSM state encoding and the initial valley profile helper
// for the terrain column server and its half-chord solver.
package terrain_pkg;
  localparam int NUM_COLS = 640;
  localparam int COL_H    = 480;
  localparam int BASE_Y   = 400;
  localparam int R_W      = 5;
  localparam int X_W      = 10;

  typedef enum logic [2:0] {INIT, IDLE, RANGE, CHORD, READ, WRITE, DONE} state_t;

  // Triangle wave of period 128 columns, amplitude 0..63.
  function automatic logic [5:0] tri_of(input logic [6:0] x);
    return x[6] ? (6'd63 - x[5:0]) : x[5:0];
  endfunction
endpackage

// File: rtl/terrain_column_server_if.sv
// Display-read and crater-carve signal bundle between the terrain server and its clients.
// Carve requests are accepted only while carve_ready is high; others are dropped.
interface terrain_column_server_if;
  import terrain_pkg::*;

  logic [X_W-1:0]   DrawX;
  logic [COL_H-1:0] terrain_data;
  logic             init_done;
  logic             carve_req;
  logic [X_W-1:0]   carve_X;
  logic [X_W-1:0]   carve_Y;
  logic [R_W-1:0]   carve_R;
  logic             carve_ready;
  logic             carve_done;

  modport master (
    output DrawX, carve_req, carve_X, carve_Y, carve_R,
    input  terrain_data, init_done, carve_ready, carve_done
  );

  modport slave (
    input  DrawX, carve_req, carve_X, carve_Y, carve_R,
    output terrain_data, init_done, carve_ready, carve_done
  );
endinterface

// File: rtl/chord_calc.sv
// Iterative half-chord solver: largest h with h*h + dx*dx <= R*R, found by counting down from R.
// Takes 1..R+1 cycles after i_start; o_valid pulses one cycle with the result on o_h.
module chord_calc
  import terrain_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_start,
  input  logic [R_W-1:0] i_dx,
  input  logic [R_W-1:0] i_r,
  output logic [R_W-1:0] o_h,
  output logic           o_valid
);

  logic [R_W-1:0]   r_h;
  logic             r_busy;
  logic             r_valid;
  logic [2*R_W-1:0] w_hh;
  logic [2*R_W-1:0] w_dd;
  logic [2*R_W-1:0] w_rr;
  logic [2*R_W:0]   w_sum;

  assign w_hh  = {{R_W{1'b0}}, r_h}  * {{R_W{1'b0}}, r_h};
  assign w_dd  = {{R_W{1'b0}}, i_dx} * {{R_W{1'b0}}, i_dx};
  assign w_rr  = {{R_W{1'b0}}, i_r}  * {{R_W{1'b0}}, i_r};
  assign w_sum = {1'b0, w_hh} + {1'b0, w_dd};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_start) begin
        r_h    <= i_r;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_sum > {1'b0, w_rr}) begin
          r_h <= r_h - R_W'(1);
        end else begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_h     = r_h;
  assign o_valid = r_valid;

endmodule

// File: rtl/terrain_column_server.sv
// Owns the destructible terrain bitmap: serves column DrawX with 1-cycle latency and carves
// circular craters column by column (read-modify-write); requests outside IDLE are dropped.
module terrain_column_server
  import terrain_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  terrain_column_server_if.slave   bus
);

  logic [COL_H-1:0] r_mem [NUM_COLS];

  state_t           r_state;
  logic [X_W-1:0]   r_col;
  logic [X_W-1:0]   r_hi;
  logic [X_W-1:0]   r_X;
  logic [X_W-1:0]   r_Y;
  logic [R_W-1:0]   r_R;
  logic [R_W-1:0]   r_h;
  logic [COL_H-1:0] r_rd_b;
  logic [COL_H-1:0] r_tdata;
  logic             r_chord_start;
  logic             r_init_done;
  logic             r_ready;
  logic             r_done;

  logic [R_W-1:0]    w_dx;
  logic [R_W-1:0]    w_chord_h;
  logic              w_chord_vld;
  logic signed [10:0] w_xmr;
  logic [10:0]       w_xpr;
  logic              w_empty;
  logic [X_W-1:0]    w_lo;
  logic [X_W-1:0]    w_hi;
  logic signed [10:0] w_ymh;
  logic [10:0]       w_yph;
  logic [8:0]        w_mlo;
  logic [8:0]        w_mhi;
  logic [COL_H-1:0]  w_mask;
  logic [8:0]        w_g;
  logic [COL_H-1:0]  w_prof;
  logic              w_we;
  logic [COL_H-1:0]  w_wdat;

  // Column range of the crater, clipped to the screen.
  assign w_xmr   = $signed({1'b0, r_X}) - $signed({6'b0, r_R});
  assign w_xpr   = {1'b0, r_X} + {6'b0, r_R};
  assign w_empty = (w_xmr > $signed(11'(NUM_COLS - 1)));
  assign w_lo    = w_xmr[10] ? '0 : w_xmr[9:0];
  assign w_hi    = (w_xpr > 11'(NUM_COLS - 1)) ? X_W'(NUM_COLS - 1) : w_xpr[9:0];

  // Within [lo,hi] the distance never exceeds R, so R_W bits suffice.
  assign w_dx = (r_col >= r_X) ? R_W'(r_col - r_X) : R_W'(r_X - r_col);

  assign w_ymh  = $signed({1'b0, r_Y}) - $signed({6'b0, r_h});
  assign w_yph  = {1'b0, r_Y} + {6'b0, r_h};
  assign w_mlo  = w_ymh[10] ? 9'd0 : w_ymh[8:0];
  assign w_mhi  = (w_yph > 11'(COL_H - 1)) ? 9'(COL_H - 1) : w_yph[8:0];
  assign w_mask = (w_ymh > $signed(11'(COL_H - 1))) ? '0 :
                  (({COL_H{1'b1}} << w_mlo) & ({COL_H{1'b1}} >> (9'(COL_H - 1) - w_mhi)));

  assign w_g    = 9'(BASE_Y) - {3'b0, tri_of(r_col[6:0])};
  assign w_prof = {COL_H{1'b1}} << w_g;

  assign w_we   = (r_state == INIT) || (r_state == WRITE);
  assign w_wdat = (r_state == INIT) ? w_prof : (r_rd_b & ~w_mask);

  chord_calc u_chord (
    .clk     (clk),
    .reset   (reset),
    .i_start (r_chord_start),
    .i_dx    (w_dx),
    .i_r     (r_R),
    .o_h     (w_chord_h),
    .o_valid (w_chord_vld)
  );

  // Port B write; the display read below sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_col] <= w_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata <= '0;
    end else if (r_init_done) begin
      r_tdata <= r_mem[bus.DrawX];
    end else begin
      r_tdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= INIT;
      r_col         <= '0;
      r_hi          <= '0;
      r_X           <= '0;
      r_Y           <= '0;
      r_R           <= '0;
      r_h           <= '0;
      r_rd_b        <= '0;
      r_chord_start <= 1'b0;
      r_init_done   <= 1'b0;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_chord_start <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_col == X_W'(NUM_COLS - 1)) begin
            r_init_done <= 1'b1;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_col <= r_col + X_W'(1);
          end
        end
        IDLE: begin
          if (bus.carve_req) begin
            r_X     <= bus.carve_X;
            r_Y     <= bus.carve_Y;
            r_R     <= bus.carve_R;
            r_ready <= 1'b0;
            r_state <= RANGE;
          end
        end
        RANGE: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_col         <= w_lo;
            r_hi          <= w_hi;
            r_chord_start <= 1'b1;
            r_state       <= CHORD;
          end
        end
        CHORD: begin
          if (w_chord_vld) begin
            r_h     <= w_chord_h;
            r_state <= READ;
          end
        end
        READ: begin
          r_rd_b  <= r_mem[r_col];
          r_state <= WRITE;
        end
        WRITE: begin
          if (r_col == r_hi) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_col         <= r_col + X_W'(1);
            r_chord_start <= 1'b1;
            r_state       <= CHORD;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.terrain_data = r_tdata;
  assign bus.init_done    = r_init_done;
  assign bus.carve_ready  = r_ready;
  assign bus.carve_done   = r_done;

endmodule

// File: tb/tb_terrain_column_server.sv
// Bench for terrain_column_server: directed and random craters checked against a
// bitmap model built from the profile and circle equations.
module tb_terrain_column_server;
  import terrain_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  terrain_column_server_if tif();

  terrain_column_server dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  logic [COL_H-1:0] ref_mem [NUM_COLS];
  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  int t1_cols[4]  = '{0, 63, 64, 639};
  int t1_first[4] = '{400, 337, 337, 400};

  always @(negedge clk) if (tif.carve_done === 1'b1) n_done++;

  task automatic check_eq(input string tag, input logic [COL_H-1:0] got, input logic [COL_H-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_set(input logic [COL_H-1:0] d);
    for (int r = 0; r < COL_H; r++) if (d[r]) return r;
    return -1;
  endfunction

  task automatic model_init();
    for (int c = 0; c < NUM_COLS; c++) begin
      int t, g;
      t = (((c / 64) % 2) == 1) ? (63 - (c % 64)) : (c % 64);
      g = BASE_Y - t;
      for (int r = 0; r < COL_H; r++) ref_mem[c][r] = (r >= g);
    end
  endtask

  task automatic model_carve(input int x, input int y, input int rad);
    for (int c = 0; c < NUM_COLS; c++) begin
      int dx;
      dx = c - x;
      if (dx * dx <= rad * rad) begin
        for (int r = 0; r < COL_H; r++) begin
          int dy;
          dy = r - y;
          if (dx * dx + dy * dy <= rad * rad) ref_mem[c][r] = 1'b0;
        end
      end
    end
  endtask

  task automatic read_col(input int c, output logic [COL_H-1:0] d);
    tif.DrawX = X_W'(c);
    tick();
    d = tif.terrain_data;
  endtask

  task automatic sweep(input string tag);
    tif.DrawX = '0;
    tick();
    for (int c = 0; c < NUM_COLS; c++) begin
      check_eq($sformatf("%s_c%0d", tag, c), tif.terrain_data, ref_mem[c]);
      tif.DrawX = X_W'((c + 1) % NUM_COLS);
      tick();
    end
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (tif.init_done === 1'b1) break;
      tick();
    end
    check_eq(tag, COL_H'(tif.init_done), COL_H'(1));
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (tif.carve_ready === 1'b1) break;
      tick();
    end
    check_eq(tag, COL_H'(tif.carve_ready), COL_H'(1));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (tif.carve_done === 1'b1) break;
      tick();
    end
    check_eq(tag, COL_H'(tif.carve_done), COL_H'(1));
  endtask

  task automatic start_carve(input int x, input int y, input int rad);
    wait_ready("ready_to");
    tif.carve_X   = X_W'(x);
    tif.carve_Y   = X_W'(y);
    tif.carve_R   = R_W'(rad);
    tif.carve_req = 1'b1;
    tick();
    tif.carve_req = 1'b0;
  endtask

  task automatic do_carve(input int x, input int y, input int rad, input string tag);
    int d0;
    d0 = n_done;
    start_carve(x, y, rad);
    wait_done({tag, "_done_to"});
    tick();
    tick();
    check_eq({tag, "_done_cnt"}, COL_H'(n_done - d0), COL_H'(1));
    model_carve(x, y, rad);
  endtask

  initial begin
    logic [COL_H-1:0] d;
    logic [COL_H-1:0] old;
    int d0;

    reset = 1'b1;
    tif.DrawX = '0;
    tif.carve_req = 1'b0;
    tif.carve_X = '0;
    tif.carve_Y = '0;
    tif.carve_R = '0;
    repeat (3) tick();
    check_eq("rst_tdata", tif.terrain_data, '0);
    check_eq("rst_init", COL_H'(tif.init_done), '0);
    check_eq("rst_ready", COL_H'(tif.carve_ready), '0);
    check_eq("rst_done", COL_H'(tif.carve_done), '0);

    reset = 1'b0;
    tif.DrawX = 10'd5;
    tick();
    tick();
    check_eq("pre_init_tdata", tif.terrain_data, '0);
    check_eq("pre_init_flag", COL_H'(tif.init_done), '0);
    model_init();
    wait_init("init_to");
    tick();
    check_eq("init_ready", COL_H'(tif.carve_ready), COL_H'(1));

    // Initial profile at the triangle corners.
    for (int i = 0; i < 4; i++) begin
      read_col(t1_cols[i], d);
      check_eq($sformatf("t1_col%0d", t1_cols[i]), d, ref_mem[t1_cols[i]]);
      check_eq($sformatf("t1_first%0d", t1_cols[i]), COL_H'(first_set(d)), COL_H'(t1_first[i]));
    end
    sweep("init");

    do_carve(100, 420, 10, "t2");
    read_col(100, d);
    check_eq("t2_c100_hole", COL_H'(d[430:410]), '0);
    check_eq("t2_c100_rim", COL_H'({d[431], d[409]}), COL_H'(3));
    read_col(110, d);
    check_eq("t2_c110", COL_H'({d[421], d[420], d[419]}), COL_H'(5));
    read_col(90, d);
    check_eq("t2_c90", COL_H'({d[421], d[420], d[419]}), COL_H'(5));
    sweep("t2");

    do_carve(3, 478, 10, "t3");
    sweep("t3");

    // A second request while busy must be dropped.
    d0 = n_done;
    start_carve(300, 370, 15);
    tif.carve_X   = 10'd310;
    tif.carve_Y   = 10'd390;
    tif.carve_R   = 5'd5;
    tif.carve_req = 1'b1;
    repeat (12) tick();
    tif.carve_req = 1'b0;
    wait_done("t4_done_to");
    tick();
    tick();
    check_eq("t4_done_cnt", COL_H'(n_done - d0), COL_H'(1));
    model_carve(300, 370, 15);
    sweep("t4");

    // Reset in the middle of a carve restores the whole initial terrain.
    start_carve(200, 380, 20);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    tick();
    check_eq("t5_init_drop", COL_H'(tif.init_done), '0);
    reset = 1'b0;
    model_init();
    wait_init("t5_init_to");
    tick();
    check_eq("t5_ready", COL_H'(tif.carve_ready), COL_H'(1));
    read_col(200, d);
    check_eq("t5_c200", d, ref_mem[200]);
    sweep("t5");

    // Column 150 is the last column written, so the write edge is the one raising carve_done.
    tif.DrawX = 10'd150;
    old = ref_mem[150];
    d0 = n_done;
    start_carve(147, 390, 3);
    wait_done("t6_done_to");
    check_eq("t6_rbw_old", tif.terrain_data, old);
    model_carve(147, 390, 3);
    tick();
    check_eq("t6_rbw_new", tif.terrain_data, ref_mem[150]);
    tick();
    check_eq("t6_done_cnt", COL_H'(n_done - d0), COL_H'(1));
    for (int i = 0; i < 40; i++) begin
      int a;
      a = $urandom_range(0, NUM_COLS - 1);
      read_col(a, d);
      check_eq($sformatf("t6_lat_c%0d", a), d, ref_mem[a]);
    end

    do_carve(320, 450, 0, "r0");
    do_carve(1000, 300, 31, "empty");
    do_carve(400, 1000, 31, "ylow");
    sweep("dir");

    for (int k = 0; k < 8; k++) begin
      int x, y, rad;
      x   = $urandom_range(0, 700);
      y   = $urandom_range(0, 520);
      rad = $urandom_range(0, 31);
      do_carve(x, y, rad, $sformatf("rnd%0d", k));
      sweep($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
